// File: rtl/morse_pkg.sv
// Shared symbol codes, symbol type and classifier state encoding for the Morse
// symbol classifier and the downstream letter decoder.
package morse_pkg;

  typedef logic [1:0] morseSym_t;

  localparam morseSym_t SYM_DOT    = 2'b00;
  localparam morseSym_t SYM_WORD   = 2'b01;
  localparam morseSym_t SYM_LETTER = 2'b10;
  localparam morseSym_t SYM_DASH   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } clsState_t;

  // Gap symbols carry no mark energy; the decoder uses this to split letters.
  function automatic logic isGapSym(input morseSym_t s);
    return (s == SYM_LETTER) || (s == SYM_WORD);
  endfunction

endpackage

// File: rtl/morse_sym_fifo.sv
// Small show-ahead symbol FIFO with occupancy count and simultaneous push/pop,
// including push-while-full when a pop frees the slot in the same cycle.
module morse_sym_fifo
  import morse_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wrData,
  input  logic             pop,
  output logic [WIDTH-1:0] rdData,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign empty  = (level == '0);
  assign full   = (level == FULL_LVL);
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  // Head is read straight from storage; an empty FIFO presents a zero code.
  assign rdData = empty ? '0 : mem[rdPtr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (doPush) begin
        mem[wrPtr] <= wrData;
        wrPtr      <= nextPtr(wrPtr);
      end
      if (doPop) begin
        rdPtr <= nextPtr(rdPtr);
      end
      case ({doPush, doPop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/morse_symbol_classifier.sv
// Run-length Morse classifier: turns the sampled line into DOT/DASH and
// LETTER/WORD gap symbols, queued for the downstream decoder.
module morse_symbol_classifier
  import morse_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int MIN_MARK   = 1,
  parameter int DOT_MAX    = 2,
  parameter int LETTER_GAP = 3,
  parameter int WORD_GAP   = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               dataIn,
  input  logic                               symReady,
  input  logic                               clrOvf,
  output logic                               symValid,
  output logic [1:0]                         symCode,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifoLevel,
  output logic                               overflow,
  output logic                               glitch
);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] MIN_MARK_C   = CNT_W'(MIN_MARK);
  localparam logic [CNT_W-1:0] DOT_MAX_C    = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] LETTER_GAP_C = CNT_W'(LETTER_GAP);
  localparam logic [CNT_W-1:0] WORD_GAP_C   = CNT_W'(WORD_GAP);

  clsState_t        state;
  clsState_t        stateNext;
  logic [CNT_W-1:0] markLen;
  logic [CNT_W-1:0] markLenNext;
  logic [CNT_W-1:0] spaceLen;
  logic [CNT_W-1:0] spaceLenNext;
  logic             inWord;
  logic             inWordNext;
  logic             glitchNext;
  logic             pushEn;
  morseSym_t        pushSym;
  logic             popEn;
  logic             fifoFull;
  logic             fifoEmpty;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      markLen  <= '0;
      spaceLen <= '0;
      inWord   <= 1'b0;
      glitch   <= 1'b0;
    end else begin
      state    <= stateNext;
      markLen  <= markLenNext;
      spaceLen <= spaceLenNext;
      inWord   <= inWordNext;
      glitch   <= glitchNext;
    end
  end

  // The push decision is made on the same sample that ends a run, so the
  // symbol lands in the FIFO at that edge.
  always_comb begin
    stateNext    = state;
    markLenNext  = markLen;
    spaceLenNext = spaceLen;
    inWordNext   = inWord;
    glitchNext   = 1'b0;
    pushEn       = 1'b0;
    pushSym      = SYM_DOT;

    case (state)
      IDLE: begin
        if (dataIn) begin
          stateNext   = MARK;
          markLenNext = CNT_ONE;
        end
      end

      MARK: begin
        if (dataIn) begin
          markLenNext = satInc(markLen);
        end else if (markLen < MIN_MARK_C) begin
          // A discarded glitch keeps an open word's gap timing alive.
          glitchNext  = 1'b1;
          markLenNext = '0;
          if (inWord) begin
            stateNext    = SPACE;
            spaceLenNext = CNT_ONE;
          end else begin
            stateNext    = IDLE;
            spaceLenNext = '0;
          end
        end else begin
          pushEn       = 1'b1;
          pushSym      = (markLen <= DOT_MAX_C) ? SYM_DOT : SYM_DASH;
          inWordNext   = 1'b1;
          markLenNext  = '0;
          stateNext    = SPACE;
          spaceLenNext = CNT_ONE;
        end
      end

      SPACE: begin
        if (dataIn) begin
          stateNext    = MARK;
          markLenNext  = CNT_ONE;
          spaceLenNext = '0;
        end else begin
          spaceLenNext = satInc(spaceLen);
          if (spaceLenNext == LETTER_GAP_C) begin
            pushEn  = 1'b1;
            pushSym = SYM_LETTER;
          end else if (spaceLenNext == WORD_GAP_C) begin
            pushEn       = 1'b1;
            pushSym      = SYM_WORD;
            inWordNext   = 1'b0;
            stateNext    = IDLE;
            spaceLenNext = '0;
          end
        end
      end

      default: begin
        stateNext    = IDLE;
        markLenNext  = '0;
        spaceLenNext = '0;
        inWordNext   = 1'b0;
      end
    endcase
  end

  assign popEn    = symValid && symReady;
  assign symValid = !fifoEmpty;

  morse_sym_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2)
  ) symFifo (
    .clk    (clk),
    .rst    (rst),
    .push   (pushEn),
    .wrData (pushSym),
    .pop    (popEn),
    .rdData (symCode),
    .full   (fifoFull),
    .empty  (fifoEmpty),
    .level  (fifoLevel)
  );

  // A dropped symbol outranks a clear arriving in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (pushEn && fifoFull && !popEn) begin
      overflow <= 1'b1;
    end else if (clrOvf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_morse_symbol_classifier.sv
// Scoreboard bench: directed line patterns queue expected symbols, and
// per-DUT monitors compare each symbol as it is handed downstream.
module tb_morse_symbol_classifier;
  import morse_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dataIn = 1'b0;
  logic       symReady = 1'b0;
  logic       clrOvf = 1'b0;
  logic       symValid;
  logic [1:0] symCode;
  logic [2:0] fifoLevel;
  logic       overflow;
  logic       glitch;

  logic       gDataIn = 1'b0;
  logic       gReady = 1'b1;
  logic       gClr = 1'b0;
  logic       gValid;
  logic [1:0] gCode;
  logic [2:0] gLevel;
  logic       gOverflow;
  logic       gGlitch;

  int checks = 0;
  int failures = 0;
  logic [1:0] expQ[$];
  logic [1:0] expQG[$];

  always #5 clk = ~clk;

  morse_symbol_classifier #(
    .CNT_W(8), .MIN_MARK(1), .DOT_MAX(2), .LETTER_GAP(3), .WORD_GAP(7), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .dataIn(dataIn), .symReady(symReady), .clrOvf(clrOvf),
    .symValid(symValid), .symCode(symCode), .fifoLevel(fifoLevel),
    .overflow(overflow), .glitch(glitch)
  );

  morse_symbol_classifier #(
    .CNT_W(8), .MIN_MARK(2), .DOT_MAX(2), .LETTER_GAP(3), .WORD_GAP(7), .FIFO_DEPTH(4)
  ) dutG (
    .clk(clk), .rst(rst), .dataIn(gDataIn), .symReady(gReady), .clrOvf(gClr),
    .symValid(gValid), .symCode(gCode), .fifoLevel(gLevel),
    .overflow(gOverflow), .glitch(gGlitch)
  );

  task automatic checkOutput(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("[TB] FAIL %s got=%0d required=%0d", name, actual, required);
    end
  endtask

  function automatic logic [1:0] charToSym(input byte c);
    case (c)
      "D":     return SYM_DASH;
      "L":     return SYM_LETTER;
      "W":     return SYM_WORD;
      default: return SYM_DOT;
    endcase
  endfunction

  // exps holds one char per sample: '.' none, d/D/L/W the symbol that sample pushes.
  task automatic applyStimulus(input bit useG, input string bits, input string exps);
    for (int i = 0; i < bits.len(); i++) begin
      if (exps[i] != ".") begin
        if (useG) expQG.push_back(charToSym(exps[i]));
        else      expQ.push_back(charToSym(exps[i]));
      end
      if (useG) gDataIn = (bits[i] == "1");
      else      dataIn  = (bits[i] == "1");
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && symValid && symReady) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL main unexpected symbol got=%b required=none", symCode);
      end else begin
        checkOutput("main symbol", int'(symCode), int'(expQ.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && gValid && gReady) begin
      if (expQG.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL glitch-dut unexpected symbol got=%b required=none", gCode);
      end else begin
        checkOutput("glitch-dut symbol", int'(gCode), int'(expQG.pop_front()));
      end
    end
  end

  initial begin
    #12;
    checkOutput("reset symValid", symValid, 0);
    checkOutput("reset symCode", symCode, 0);
    checkOutput("reset fifoLevel", fifoLevel, 0);
    checkOutput("reset overflow", overflow, 0);
    checkOutput("reset glitch", glitch, 0);
    @(negedge clk);
    rst = 1'b0;
    symReady = 1'b1;

    // Dot, letter gap, then a rising edge cuts the gap short of a word gap.
    applyStimulus(0, "10", ".d");
    checkOutput("t1 dot valid", symValid, 1);
    checkOutput("t1 dot code", symCode, SYM_DOT);
    applyStimulus(0, "0", ".");
    checkOutput("t1 intra gap silent", symValid, 0);
    applyStimulus(0, "0", "L");
    checkOutput("t1 letter valid", symValid, 1);
    checkOutput("t1 letter code", symCode, SYM_LETTER);
    applyStimulus(0, "10000000", ".d.L...W");

    // Dash then a full word gap; the eighth quiet sample emits nothing.
    applyStimulus(0, "1110000000", "...D.L...W");
    checkOutput("t2 word valid", symValid, 1);
    checkOutput("t2 word code", symCode, SYM_WORD);
    applyStimulus(0, "0", ".");
    checkOutput("t2 idle silent", symValid, 0);

    // SOS
    applyStimulus(0, "10101000", ".d.d.d.L");
    applyStimulus(0, "11101110111000", "...D...D...D.L");
    applyStimulus(0, "101010000000", ".d.d.d.L...W");
    applyStimulus(0, "0", ".");

    // Fill with the line stalled; the word gap is the dropped fifth symbol.
    symReady = 1'b0;
    applyStimulus(0, "1000111000000", ".d.L...D.L...");
    checkOutput("t4 level full", fifoLevel, 4);
    checkOutput("t4 no overflow yet", overflow, 0);
    checkOutput("t4 head held", symCode, SYM_DOT);
    applyStimulus(0, "0", ".");
    checkOutput("t4 level after drop", fifoLevel, 4);
    checkOutput("t4 overflow set", overflow, 1);
    checkOutput("t4 head still held", symCode, SYM_DOT);
    symReady = 1'b1;
    applyStimulus(0, "00000", ".....");
    checkOutput("t4 drained", fifoLevel, 0);
    checkOutput("t4 overflow sticky", overflow, 1);
    clrOvf = 1'b1;
    applyStimulus(0, "0", ".");
    clrOvf = 1'b0;
    checkOutput("t4 overflow cleared", overflow, 0);

    // Glitch filter on the MIN_MARK=2 instance.
    applyStimulus(1, "10", "..");
    checkOutput("t5 glitch pulse", gGlitch, 1);
    checkOutput("t5 glitch no symbol", gValid, 0);
    applyStimulus(1, "0", ".");
    checkOutput("t5 glitch one cycle", gGlitch, 0);
    applyStimulus(1, "00000000", "........");
    checkOutput("t5 no gap after glitch", gValid, 0);
    applyStimulus(1, "110", "..d");
    applyStimulus(1, "10", "..");
    checkOutput("t5 glitch in word", gGlitch, 1);
    applyStimulus(1, "000000", ".L...W");
    applyStimulus(1, "0", ".");

    // Asynchronous reset in the middle of a dash with two symbols queued.
    symReady = 1'b0;
    applyStimulus(0, "1000", "....");
    checkOutput("t6 queued before reset", fifoLevel, 2);
    applyStimulus(0, "1", ".");
    dataIn = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6 async symValid", symValid, 0);
    checkOutput("t6 async fifoLevel", fifoLevel, 0);
    checkOutput("t6 async symCode", symCode, 0);
    @(negedge clk);
    rst = 1'b0;
    symReady = 1'b1;
    applyStimulus(0, "00000", ".....");
    checkOutput("t6 nothing after release", symValid, 0);
    checkOutput("t6 level after release", fifoLevel, 0);

    checkOutput("main queue drained", expQ.size(), 0);
    checkOutput("glitch-dut queue drained", expQG.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
